// File: rtl/alarm_ctrl.sv
// Alarm controller: rings on a rising match of time and alarm, supports stop/snooze, flags unattended timeouts.
// Latency: every output is registered, so a state change is visible one clk after the event that causes it.
// Backpressure: none; all inputs are level or one-clk pulse strobes that are sampled on every clk.
//
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   tick_1hz             one-clk pulse per second
//   time_hm, alarm_hm    {hour[15:8], minute[7:0]}, binary, 24-hour
//   alarm_en, adjust     armed switch level; adjust-stage active level
//   btn_stop, btn_snooze debounced one-clk button pulses
//   buzzer               sounder drive (beeps at 1 s on / 1 s off while ringing)
//   state                00 IDLE, 01 RINGING, 10 SNOOZE
//   missed               an alarm rang out unattended
//   snoozes_used         snoozes taken in the current alarm event
module alarm_ctrl #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic [15:0] time_hm,
    input  logic [15:0] alarm_hm,
    input  logic        alarm_en,
    input  logic        adjust,
    input  logic        btn_stop,
    input  logic        btn_snooze,
    output logic        buzzer,
    output logic [1:0]  state,
    output logic        missed,
    output logic [2:0]  snoozes_used
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RINGING = 2'b01,
        SNOOZE  = 2'b10
    } state_t;

    localparam logic [15:0] SNOOZE_LOAD = 16'(SNOOZE_MIN * 60);
    localparam logic [7:0]  RING_LAST   = 8'(RING_TIMEOUT_S - 1);
    localparam logic [2:0]  SNOOZE_MAX  = 3'(MAX_SNOOZE);

    state_t      state_q, state_n;
    logic        match, match_q;
    logic        phase_q, phase_n;
    logic [7:0]  ring_cnt_q, ring_cnt_n;
    logic [15:0] snz_cnt_q, snz_cnt_n;
    logic        missed_n;
    logic [2:0]  snoozes_n;

    assign match = (time_hm == alarm_hm) & alarm_en & ~adjust;
    assign state = state_q;

    always_comb begin
        state_n    = state_q;
        phase_n    = phase_q;
        ring_cnt_n = ring_cnt_q;
        snz_cnt_n  = snz_cnt_q;
        missed_n   = missed;
        snoozes_n  = snoozes_used;

        if (!alarm_en || adjust) begin
            // Disarming or adjusting the clock overrides every other event.
            state_n = IDLE;
            phase_n = 1'b0;
            if (!alarm_en) begin
                missed_n = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (btn_stop) begin
                        missed_n = 1'b0;
                    end
                    // Edge-triggered so a stopped alarm stays quiet for the rest of its minute.
                    // A coincident tick is deliberately not counted.
                    if (match && !match_q) begin
                        state_n    = RINGING;
                        ring_cnt_n = 8'd0;
                        snoozes_n  = 3'd0;
                        phase_n    = 1'b1;
                    end
                end
                RINGING: begin
                    if (btn_stop) begin
                        state_n = IDLE;
                        phase_n = 1'b0;
                    end else if (btn_snooze && (snoozes_used < SNOOZE_MAX)) begin
                        state_n   = SNOOZE;
                        snoozes_n = snoozes_used + 3'd1;
                        snz_cnt_n = SNOOZE_LOAD;
                        phase_n   = 1'b0;
                    end else if (tick_1hz) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_n  = IDLE;
                            missed_n = 1'b1;
                            phase_n  = 1'b0;
                        end else begin
                            ring_cnt_n = ring_cnt_q + 8'd1;
                            phase_n    = ~phase_q;
                        end
                    end
                end
                SNOOZE: begin
                    if (btn_stop) begin
                        state_n = IDLE;
                    end else if (tick_1hz) begin
                        snz_cnt_n = snz_cnt_q - 16'd1;
                        // Counter loaded with N expires on the N-th tick.
                        if (snz_cnt_q == 16'd1) begin
                            state_n    = RINGING;
                            ring_cnt_n = 8'd0;
                            phase_n    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    phase_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            match_q      <= 1'b0;
            phase_q      <= 1'b0;
            ring_cnt_q   <= 8'd0;
            snz_cnt_q    <= 16'd0;
            missed       <= 1'b0;
            snoozes_used <= 3'd0;
            buzzer       <= 1'b0;
        end else begin
            state_q      <= state_n;
            match_q      <= match;
            phase_q      <= phase_n;
            ring_cnt_q   <= ring_cnt_n;
            snz_cnt_q    <= snz_cnt_n;
            missed       <= missed_n;
            snoozes_used <= snoozes_n;
            // Registered from next-state so the buzzer sounds on the first clk of RINGING.
            buzzer       <= (state_n == RINGING) & phase_n;
        end
    end

endmodule
